branch_predictor_bht: RTL and testbench

Dynamic successor to the static backward-taken/forward-not-taken predictor in the instruction-fetch stage. The block keeps a parametrised, direct-mapped table of saturating counters indexed by PC. Each counter is trained by resolved branches from the execute stage, and predicts conditional branches in the same cycle as fetch. Entries that have never been trained fall back to the static rule (backward taken, forward not taken). JAL is always predicted taken.

---
 rtl/branch_predictor_bht.sv | 115 +++++++++++
 tb/tb_branch_predictor_bht.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Direct-mapped table of saturating counters predicting conditional branches at fetch.
// Untrained entries fall back to backward-taken / forward-not-taken; JAL is optionally always taken.

module bht_entry #(
  parameter int COUNTER_BITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    taken,
  output logic                    valid,
  output logic [COUNTER_BITS-1:0] ctr
);
  localparam logic [COUNTER_BITS-1:0] WEAK_T   = COUNTER_BITS'(1) << (COUNTER_BITS - 1);
  localparam logic [COUNTER_BITS-1:0] WEAK_NT  = WEAK_T - COUNTER_BITS'(1);
  localparam logic [COUNTER_BITS-1:0] CTR_MAX  = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctr   <= '0;
    end else if (wr_en) begin
      if (!valid) begin
        // First training seeds the weak state in the direction of the outcome
        valid <= 1'b1;
        ctr   <= taken ? WEAK_T : WEAK_NT;
      end else if (taken && ctr != CTR_MAX) begin
        ctr <= ctr + COUNTER_BITS'(1);
      end else if (!taken && ctr != '0) begin
        ctr <= ctr - COUNTER_BITS'(1);
      end
    end
  end
endmodule

module branch_predictor_bht #(
  parameter int BHT_ENTRIES  = 64,
  parameter int COUNTER_BITS = 2,
  parameter int JAL_PREDICT  = 1
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o,
  output logic        branch_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_req_t;

  upd_req_t                                   upd;
  logic [BHT_ENTRIES-1:0]                     valid_q;
  logic [BHT_ENTRIES-1:0][COUNTER_BITS-1:0]   ctr_q;
  logic [IDX_W-1:0]                           lk_idx;
  logic [31:0]                                b_imm;
  logic [31:0]                                j_imm;
  logic [6:0]                                 opcode;
  logic                                       unused_upd_pc;

  assign upd.vld   = upd_valid_i;
  assign upd.idx   = upd_pc_i[IDX_W+1:2];
  assign upd.taken = upd_taken_i;

  // Tagless table: only the index bits of the update PC matter
  assign unused_upd_pc = ^{upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

  genvar e;
  generate
    for (e = 0; e < BHT_ENTRIES; e++) begin : g_ent
      bht_entry #(
        .COUNTER_BITS (COUNTER_BITS)
      ) u_ent (
        .clk   (clk),
        .rst   (rst_i),
        .wr_en (upd.vld && (upd.idx == IDX_W'(e))),
        .taken (upd.taken),
        .valid (valid_q[e]),
        .ctr   (ctr_q[e])
      );
    end
  endgenerate

  assign opcode = instr_i[6:0];
  assign lk_idx = pc_i[IDX_W+1:2];
  assign b_imm  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
  assign j_imm  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};

  // Lookup reads the registered table, so a same-cycle update is not bypassed
  always_comb begin
    branch_o = 1'b0;
    pc_o     = '0;
    if (!rst_i) begin
      if (opcode == OP_BRANCH) begin
        branch_o = valid_q[lk_idx] ? ctr_q[lk_idx][COUNTER_BITS-1] : instr_i[31];
        if (branch_o) pc_o = pc_i + b_imm;
      end else if (opcode == OP_JAL && JAL_PREDICT == 1) begin
        branch_o = 1'b1;
        pc_o     = pc_i + j_imm;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht (64 entries, 2-bit counters, JAL predicted).

module tb_branch_predictor_bht;
  logic        clk;
  logic        rst_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [31:0] pc_o;
  logic        branch_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;

  int n_tests = 0;
  int n_fail  = 0;

  branch_predictor_bht #(
    .BHT_ENTRIES  (64),
    .COUNTER_BITS (2),
    .JAL_PREDICT  (1)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .pc_o        (pc_o),
    .branch_o    (branch_o),
    .upd_valid_i (upd_valid_i),
    .upd_pc_i    (upd_pc_i),
    .upd_taken_i (upd_taken_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] binstr(input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd1, 5'd2, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] jinstr(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                       input logic exp_b, input logic [31:0] exp_pc);
    pc_i    = pc;
    instr_i = instr;
    #1;
    chk({tag, ".branch"}, {31'd0, branch_o}, {31'd0, exp_b});
    chk({tag, ".pc"}, pc_o, exp_pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken);
    upd_valid_i = 1'b1;
    upd_pc_i    = pc;
    upd_taken_i = taken;
    tick();
    upd_valid_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    instr_i     = '0;
    pc_i        = '0;
    upd_valid_i = 1'b0;
    upd_pc_i    = '0;
    upd_taken_i = 1'b0;
    #2;
    probe("rst_gate", 32'h100, binstr(-8), 1'b0, 32'h0);
    tick();
    rst_i = 1'b0;

    // static fallback on an empty table
    probe("fb_back", 32'h100, binstr(-8), 1'b1, 32'hF8);
    probe("fb_fwd",  32'h100, binstr(16), 1'b0, 32'h0);

    // training idx 0: 01 -> 00 -> 00
    train(32'h100, 1'b0);
    probe("nt1", 32'h100, binstr(-8), 1'b0, 32'h0);
    train(32'h100, 1'b0);
    train(32'h100, 1'b0);
    probe("nt3", 32'h100, binstr(-8), 1'b0, 32'h0);
    train(32'h100, 1'b1);
    probe("t1_01", 32'h100, binstr(-8), 1'b0, 32'h0);
    train(32'h100, 1'b1);
    probe("t2_10", 32'h100, binstr(-8), 1'b1, 32'hF8);
    train(32'h100, 1'b1);
    train(32'h100, 1'b1);
    train(32'h100, 1'b1);
    train(32'h100, 1'b0);
    probe("sat_hi", 32'h100, binstr(-8), 1'b1, 32'hF8);
    train(32'h100, 1'b0);
    probe("dec_01", 32'h100, binstr(-8), 1'b0, 32'h0);

    // same-cycle hazard: 0x200 aliases idx 0, currently 01
    upd_valid_i = 1'b1;
    upd_pc_i    = 32'h200;
    upd_taken_i = 1'b1;
    probe("haz_pre", 32'h200, binstr(16), 1'b0, 32'h0);
    tick();
    upd_valid_i = 1'b0;
    probe("haz_post", 32'h200, binstr(16), 1'b1, 32'h210);

    // aliasing: 0x104 and 0x204 share idx 1
    train(32'h104, 1'b1);
    train(32'h104, 1'b1);
    probe("alias", 32'h204, binstr(16), 1'b1, 32'h214);

    probe("jal_fwd", 32'h300, jinstr(32'h800), 1'b1, 32'hB00);
    probe("jal_bwd", 32'h300, jinstr(-4),      1'b1, 32'h2FC);
    probe("jalr",    32'h300, 32'h800080E7,    1'b0, 32'h0);
    probe("wrap",    32'h4,   binstr(-8),      1'b1, 32'hFFFF_FFFC);

    // reset mid-run with an update pending to the fresh idx 2
    rst_i       = 1'b1;
    upd_valid_i = 1'b1;
    upd_pc_i    = 32'h208;
    upd_taken_i = 1'b1;
    probe("rst_mid", 32'h200, binstr(16), 1'b0, 32'h0);
    tick();
    rst_i       = 1'b0;
    upd_valid_i = 1'b0;
    probe("post_idx0", 32'h200, binstr(16), 1'b0, 32'h0);
    probe("post_idx1", 32'h204, binstr(16), 1'b0, 32'h0);
    probe("post_drop", 32'h208, binstr(16), 1'b0, 32'h0);
    probe("post_back", 32'h100, binstr(-8), 1'b1, 32'hF8);
    train(32'h100, 1'b1);
    probe("post_seed", 32'h100, binstr(16), 1'b1, 32'h110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
